// File: rtl/pe_if.sv
//------------------------------------------------------------------------------
// pe_if : pixel-bank, control and result bundle of the pe processing element.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pe_if #(
    parameter int NUM_PIXELS = 1
);
    localparam int c_width = 8 * NUM_PIXELS + 1;

    logic               Ack;
    logic [8:0]         red_exp;
    logic [8:0]         green_exp;
    logic [8:0]         blue_exp;
    logic [7:0]         threshold;
    logic [8:0]         desired_bg;
    logic               Start_Sum;
    logic               Start_BgRemoval;
    logic [c_width-1:0] red_in;
    logic [c_width-1:0] green_in;
    logic [c_width-1:0] blue_in;
    logic [c_width-1:0] red_out;
    logic [c_width-1:0] green_out;
    logic [c_width-1:0] blue_out;
    logic [c_width-1:0] red_sum;
    logic [c_width-1:0] green_sum;
    logic [c_width-1:0] blue_sum;
    logic               Qi;
    logic               Qbgi;
    logic               Qbg;
    logic               Qbgd;
    logic               Qbad;
    logic               Qsi;
    logic               Qs;
    logic               Qsd;

    modport master (
        output Ack, red_exp, green_exp, blue_exp, threshold, desired_bg,
               Start_Sum, Start_BgRemoval, red_in, green_in, blue_in,
        input  red_out, green_out, blue_out, red_sum, green_sum, blue_sum,
               Qi, Qbgi, Qbg, Qbgd, Qbad, Qsi, Qs, Qsd
    );

    modport slave (
        input  Ack, red_exp, green_exp, blue_exp, threshold, desired_bg,
               Start_Sum, Start_BgRemoval, red_in, green_in, blue_in,
        output red_out, green_out, blue_out, red_sum, green_sum, blue_sum,
               Qi, Qbgi, Qbg, Qbgd, Qbad, Qsi, Qs, Qsd
    );
endinterface

`default_nettype wire

// File: rtl/pe.sv
//------------------------------------------------------------------------------
// pe : pixel processing element - per-channel pixel sums and background removal.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pe #(
    parameter int NUM_PIXELS = 1
) (
    input  logic Clk,
    input  logic Reset,
    pe_if.slave  bus
);
    localparam int c_width = 8 * NUM_PIXELS + 1;
    localparam int c_idx_w = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_PIXELS - 1);

    typedef enum logic [7:0] {
        S_QI   = 8'b1000_0000,
        S_QBGI = 8'b0100_0000,
        S_QBG  = 8'b0010_0000,
        S_QBGD = 8'b0001_0000,
        S_QBAD = 8'b0000_1000,
        S_QSI  = 8'b0000_0100,
        S_QS   = 8'b0000_0010,
        S_QSD  = 8'b0000_0001
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_idx_w-1:0]   r_idx;
    logic                 w_last;

    logic [7:0]           w_red_in   [NUM_PIXELS];
    logic [7:0]           w_green_in [NUM_PIXELS];
    logic [7:0]           w_blue_in  [NUM_PIXELS];
    logic [7:0]           r_red_out   [NUM_PIXELS];
    logic [7:0]           r_green_out [NUM_PIXELS];
    logic [7:0]           r_blue_out  [NUM_PIXELS];
    logic [c_width-1:0]   r_red_sum;
    logic [c_width-1:0]   r_green_sum;
    logic [c_width-1:0]   r_blue_sum;

    logic [7:0]           w_pix_r;
    logic [7:0]           w_pix_g;
    logic [7:0]           w_pix_b;
    logic                 w_match;
    logic                 w_unused;

    // |pix - ref| <= tol, evaluated in 10-bit signed arithmetic
    function automatic logic within_tol(input logic [7:0] pix,
                                        input logic [8:0] ref_v,
                                        input logic [7:0] tol);
        logic signed [9:0] diff;
        logic        [9:0] mag;
        diff = $signed({2'b00, pix}) - $signed({1'b0, ref_v});
        mag  = diff[9] ? $unsigned(-diff) : $unsigned(diff);
        return (mag <= {2'b00, tol});
    endfunction

    for (genvar i = 0; i < NUM_PIXELS; i++) begin : g_pix
        assign w_red_in[i]               = bus.red_in[8*i +: 8];
        assign w_green_in[i]             = bus.green_in[8*i +: 8];
        assign w_blue_in[i]              = bus.blue_in[8*i +: 8];
        assign bus.red_out[8*i +: 8]     = r_red_out[i];
        assign bus.green_out[8*i +: 8]   = r_green_out[i];
        assign bus.blue_out[8*i +: 8]    = r_blue_out[i];
    end

    assign bus.red_out[c_width-1]   = 1'b0;
    assign bus.green_out[c_width-1] = 1'b0;
    assign bus.blue_out[c_width-1]  = 1'b0;

    assign bus.red_sum   = r_red_sum;
    assign bus.green_sum = r_green_sum;
    assign bus.blue_sum  = r_blue_sum;

    assign bus.Qi   = r_state[7];
    assign bus.Qbgi = r_state[6];
    assign bus.Qbg  = r_state[5];
    assign bus.Qbgd = r_state[4];
    assign bus.Qbad = r_state[3];
    assign bus.Qsi  = r_state[2];
    assign bus.Qs   = r_state[1];
    assign bus.Qsd  = r_state[0];

    assign w_pix_r = w_red_in[r_idx];
    assign w_pix_g = w_green_in[r_idx];
    assign w_pix_b = w_blue_in[r_idx];
    assign w_last  = (r_idx == c_last_idx);

    assign w_match = within_tol(w_pix_r, bus.red_exp,   bus.threshold) &&
                     within_tol(w_pix_g, bus.green_exp, bus.threshold) &&
                     within_tol(w_pix_b, bus.blue_exp,  bus.threshold);

    assign w_unused = ^{bus.desired_bg[8], bus.red_in[c_width-1],
                        bus.green_in[c_width-1], bus.blue_in[c_width-1]};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_QI;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_QI: begin
                if (bus.Start_Sum && bus.Start_BgRemoval) begin
                    w_next = S_QBAD;
                end else if (bus.Start_Sum) begin
                    w_next = S_QSI;
                end else if (bus.Start_BgRemoval) begin
                    w_next = S_QBGI;
                end
            end
            S_QSI:  w_next = S_QS;
            S_QS:   if (w_last) w_next = S_QSD;
            S_QSD:  if (bus.Ack) w_next = S_QI;
            S_QBGI: w_next = S_QBG;
            S_QBG:  if (w_last) w_next = S_QBGD;
            S_QBGD: if (bus.Ack) w_next = S_QI;
            S_QBAD: if (bus.Ack) w_next = S_QI;
            default: w_next = S_QI;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_idx       <= '0;
            r_red_sum   <= '0;
            r_green_sum <= '0;
            r_blue_sum  <= '0;
            for (int i = 0; i < NUM_PIXELS; i++) begin
                r_red_out[i]   <= '0;
                r_green_out[i] <= '0;
                r_blue_out[i]  <= '0;
            end
        end else begin
            case (r_state)
                S_QSI: begin
                    r_idx       <= '0;
                    r_red_sum   <= '0;
                    r_green_sum <= '0;
                    r_blue_sum  <= '0;
                end
                S_QS: begin
                    r_red_sum   <= r_red_sum   + {{(c_width-8){1'b0}}, w_pix_r};
                    r_green_sum <= r_green_sum + {{(c_width-8){1'b0}}, w_pix_g};
                    r_blue_sum  <= r_blue_sum  + {{(c_width-8){1'b0}}, w_pix_b};
                    r_idx       <= w_last ? '0 : r_idx + c_idx_w'(1);
                end
                S_QBGI: begin
                    r_idx <= '0;
                end
                S_QBG: begin
                    // A matching pixel gets the replacement value on all channels
                    if (w_match) begin
                        r_red_out[r_idx]   <= bus.desired_bg[7:0];
                        r_green_out[r_idx] <= bus.desired_bg[7:0];
                        r_blue_out[r_idx]  <= bus.desired_bg[7:0];
                    end else begin
                        r_red_out[r_idx]   <= w_pix_r;
                        r_green_out[r_idx] <= w_pix_g;
                        r_blue_out[r_idx]  <= w_pix_b;
                    end
                    r_idx <= w_last ? '0 : r_idx + c_idx_w'(1);
                end
                default: begin
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_pe.sv
//------------------------------------------------------------------------------
// tb_pe : directed scoreboard bench for pe with a two-pixel bank.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pe;
    localparam int NP = 2;
    localparam int W  = 8 * NP + 1;

    localparam logic [7:0] QI   = 8'h80;
    localparam logic [7:0] QBGI = 8'h40;
    localparam logic [7:0] QBG  = 8'h20;
    localparam logic [7:0] QBGD = 8'h10;
    localparam logic [7:0] QBAD = 8'h08;
    localparam logic [7:0] QSI  = 8'h04;
    localparam logic [7:0] QS   = 8'h02;
    localparam logic [7:0] QSD  = 8'h01;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [7:0]     sq[$];
    logic [6*W-1:0] dq[$];

    int pr[NP], pg[NP], pb[NP];
    logic [W-1:0] cur_ro, cur_go, cur_bo, cur_rs, cur_gs, cur_bs;

    always #5 clk = ~clk;

    pe_if #(.NUM_PIXELS(NP)) bus ();

    pe #(.NUM_PIXELS(NP)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [W-1:0] pack(input int p1, input int p0);
        logic [7:0] b1, b0;
        b1 = 8'(p1);
        b0 = 8'(p0);
        return {1'b0, b1, b0};
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic push_data();
        dq.push_back({cur_ro, cur_go, cur_bo, cur_rs, cur_gs, cur_bs});
    endtask

    task automatic check_state(input string tag);
        logic [7:0] o, e;
        o = {bus.Qi, bus.Qbgi, bus.Qbg, bus.Qbgd, bus.Qbad, bus.Qsi, bus.Qs, bus.Qsd};
        total++;
        if (sq.size() == 0) begin
            bad++;
            $error("FAIL %s: state scoreboard empty, observed=%b", tag, o);
        end else begin
            e = sq.pop_front();
            assert (o === e) else begin
                bad++;
                $error("FAIL %s: state observed=%b expected=%b", tag, o, e);
            end
        end
    endtask

    task automatic check_data(input string tag);
        logic [6*W-1:0] o, e;
        o = {bus.red_out, bus.green_out, bus.blue_out,
             bus.red_sum, bus.green_sum, bus.blue_sum};
        total++;
        if (dq.size() == 0) begin
            bad++;
            $error("FAIL %s: data scoreboard empty, observed=%h", tag, o);
        end else begin
            e = dq.pop_front();
            assert (o === e) else begin
                bad++;
                $error("FAIL %s: data observed=%h expected=%h", tag, o, e);
            end
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        bus.Start_Sum       = 1'b0;
        bus.Start_BgRemoval = 1'b0;
        check_state(tag);
    endtask

    task automatic set_pixels();
        bus.red_in   = pack(pr[1], pr[0]);
        bus.green_in = pack(pg[1], pg[0]);
        bus.blue_in  = pack(pb[1], pb[0]);
    endtask

    task automatic bg_op(input string tag, input int re, input int ge, input int be,
                         input int thr, input int des);
        int er[NP], eg[NP], eb[NP];
        bus.red_exp    = 9'(re);
        bus.green_exp  = 9'(ge);
        bus.blue_exp   = 9'(be);
        bus.threshold  = 8'(thr);
        bus.desired_bg = 9'(des);
        for (int i = 0; i < NP; i++) begin
            if (iabs(pr[i] - re) <= thr && iabs(pg[i] - ge) <= thr &&
                iabs(pb[i] - be) <= thr) begin
                er[i] = des % 256; eg[i] = des % 256; eb[i] = des % 256;
            end else begin
                er[i] = pr[i]; eg[i] = pg[i]; eb[i] = pb[i];
            end
        end
        bus.Ack = 1'b1;
        bus.Start_BgRemoval = 1'b1;
        sq.push_back(QBGI); sq.push_back(QBG); sq.push_back(QBG);
        sq.push_back(QBGD); sq.push_back(QI);
        cur_ro = pack(er[1], er[0]);
        cur_go = pack(eg[1], eg[0]);
        cur_bo = pack(eb[1], eb[0]);
        push_data();
        for (int i = 0; i < 5; i++) step(tag);
        bus.Ack = 1'b0;
        check_data(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.Ack = 1'b0; bus.Start_Sum = 1'b0; bus.Start_BgRemoval = 1'b0;
        bus.red_exp = '0; bus.green_exp = '0; bus.blue_exp = '0;
        bus.threshold = '0; bus.desired_bg = '0;
        bus.red_in = '0; bus.green_in = '0; bus.blue_in = '0;
        cur_ro = '0; cur_go = '0; cur_bo = '0; cur_rs = '0; cur_gs = '0; cur_bs = '0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        sq.push_back(QI); push_data();
        check_state("reset_state");
        check_data("reset_data");
        rst_n = 1'b1;
        sq.push_back(QI);
        step("idle");

        // Sum over two pixels
        pr[0] = 61; pg[0] = 133; pb[0] = 198;
        pr[1] = 20; pg[1] = 240; pb[1] = 5;
        set_pixels();
        bus.Start_Sum = 1'b1;
        sq.push_back(QSI); sq.push_back(QS); sq.push_back(QS);
        sq.push_back(QSD); sq.push_back(QSD);
        cur_rs = W'(pr[0] + pr[1]);
        cur_gs = W'(pg[0] + pg[1]);
        cur_bs = W'(pb[0] + pb[1]);
        push_data();
        for (int i = 0; i < 5; i++) step("sum_fsm");
        check_data("sum_result");
        bus.Ack = 1'b1;
        sq.push_back(QI);
        step("sum_ack");
        bus.Ack = 1'b0;
        push_data();
        check_data("sum_hold");

        bg_op("bg_exact",   61, 133, 198, 0,   10);
        bg_op("bg_thr1",    61, 133, 200, 1,   10);
        bg_op("bg_thr2",    61, 133, 200, 2,   10);
        bg_op("bg_negdiff", 22, 238, 7,   2,   9'h1AB);
        bg_op("bg_exp9bit", 256, 240, 5,  255, 9'h055);

        // Both starts together
        bus.Start_Sum = 1'b1;
        bus.Start_BgRemoval = 1'b1;
        sq.push_back(QBAD); sq.push_back(QBAD);
        step("bad_enter");
        step("bad_hold");
        push_data();
        check_data("bad_data");
        bus.Ack = 1'b1;
        sq.push_back(QI);
        step("bad_ack");
        bus.Ack = 1'b0;

        // Reset while summing
        bus.Start_Sum = 1'b1;
        sq.push_back(QSI); sq.push_back(QS);
        step("abort_qsi");
        step("abort_qs");
        rst_n = 1'b0;
        #1;
        cur_ro = '0; cur_go = '0; cur_bo = '0; cur_rs = '0; cur_gs = '0; cur_bs = '0;
        sq.push_back(QI); push_data();
        check_state("abort_state");
        check_data("abort_data");
        @(negedge clk);
        rst_n = 1'b1;
        sq.push_back(QI);
        step("abort_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/pe.md
Name: pe

Overview:
- Pixel processing element for the background remover.
- Holds a bank of NUM_PIXELS RGB pixels presented on packed input buses.
- Operation 1 (Sum): accumulates per-channel pixel sums.
- Operation 2 (BG removal): replaces each pixel close to an expected background colour (within threshold on every channel) with a desired background value.
- Sequenced by a one-hot FSM with Ack handshake; state bits are exported for the surrounding controller.

Parameters:
NUM_PIXELS, 1, number of 8-bit pixels per channel bus; bus width W = 8*NUM_PIXELS+1, pixel i occupies bits [8i+7:8i], top bit unused.

Ports:
Clk  in  1  system clock, rising-edge.
Reset  in  1  asynchronous, active-low reset.
Ack  in  1  acknowledge; releases done/error states.
red_exp  in  9  expected background red; unsigned.
green_exp  in  9  expected background green.
blue_exp  in  9  expected background blue.
threshold  in  8  per-channel match tolerance, unsigned.
desired_bg  in  9  replacement value; bits [7:0] written to all three channels.
Start_Sum  in  1  start sum operation, sampled in Qi.
Start_BgRemoval  in  1  start background removal, sampled in Qi.
red_in  in  W  packed input red pixels; green_in, blue_in same.
red_out  out  W  packed result red pixels; green_out, blue_out same.
Qi, Qbgi, Qbg, Qbgd, Qbad, Qsi, Qs, Qsd  out  1 each  one-hot state flags.
red_sum  out  W  sum of red pixels; green_sum, blue_sum same.

Behaviour:
- All outputs registered. Reset low (async):
  - state = Qi, pixel index = 0.
  - All *_out and *_sum = 0.
- Unused top bit of *_out is always 0. Inputs must be held stable during an operation.
- Qi (idle):
  - Start_Sum=1 and Start_BgRemoval=0 -> Qsi.
  - Start_BgRemoval=1 and Start_Sum=0 -> Qbgi.
  - Both 1 -> Qbad.
  - Neither -> stay.
- Qsi: clear all three sums, index = 0 -> Qs.
- Qs: each clock add pixel[index] (zero-extended) of each channel into its sum, index++. After pixel NUM_PIXELS-1 is added -> Qsd.
- Qsd: sums hold. Ack=1 -> Qi, else stay.
- Qbgi: index = 0 -> Qbg. *_out unchanged until written.
- Qbg: each clock process pixel[index]:
  - match = |r-red_exp| <= threshold AND |g-green_exp| <= threshold AND |b-blue_exp| <= threshold.
  - Differences are computed in 10-bit signed arithmetic with the pixel zero-extended.
  - match -> all three out pixels = desired_bg[7:0]; else out pixel = in pixel.
  - index++. After the last pixel -> Qbgd.
- Qbgd: outputs hold. Ack=1 -> Qi.
- Qbad: no datapath change. Ack=1 -> Qi.
- Latency, with start sampled at edge k:
  - Sum: Qsi after k, Qs after k+1, Qsd after k+1+NUM_PIXELS.
  - BG removal: same timing.
- Ack high on the same edge the done state is entered has no effect that edge; it is honoured the next edge. Ack in any other state is ignored.
- Start inputs outside Qi are ignored.
- Sums cannot overflow: W bits exceeds 8+clog2(NUM_PIXELS).
- Results of one operation persist through the other operation and through idle; only reset or the next same-type operation changes them.
- Reset mid-operation aborts immediately to Qi with all outputs cleared.
- Exactly one Q flag is high at all times.

Test Plan:
- Reset low for 5 cycles -> Qi=1, all outputs 0. Release, idle 1 cycle -> still Qi.
- red/green/blue_in = 61/133/198, Start_Sum pulse 1 cycle, Ack=0:
  - Qsi, then Qs, then Qsd.
  - red_sum=61, green_sum=133, blue_sum=198.
  - Raise Ack -> Qi next cycle, sums hold.
- Same pixels, exp = 61/133/198, threshold=0, desired_bg=10, Start_BgRemoval pulse, Ack=1:
  - Qbgi, Qbg, Qbgd, Qi.
  - red/green/blue_out = 10/10/10; sums still 61/133/198.
- exp = 61/133/200, threshold=1 -> outputs unchanged 61/133/198.
- Same inputs with threshold=2 -> outputs 10/10/10.
- Start_Sum and Start_BgRemoval both high in Qi -> Qbad, outputs unchanged; Ack -> Qi.
- Reset asserted while in Qs -> Qi, all outputs 0.
